// File: rtl/sobel_mag.sv
// Sobel L1 gradient magnitude normalised to 8 bits; optional pixel-address window via SOBEL_MAG_WINDOW_EN.
// Latency 2 clocks, one pixel per clock, no handshake and no backpressure (always accepts).
module sobel_mag #(
   parameter int STARTADDRESS = 770,
   parameter int ENDADDRESS   = 261758
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       startEn,
   input  logic [8:0] sobelX,
   input  logic [8:0] sobelY,
   output logic [7:0] normalisedMag
);

   logic [9:0] abs_x;
   logic [9:0] abs_y;
   logic [9:0] mag_sum;
   logic [9:0] mag_half;
   logic [9:0] unnormalisedMag;
   logic       gate;
   logic       gate_q;

   // Sign-extend to 10 bits before negating so |-256| = 256 is representable.
   always_comb begin
      abs_x   = sobelX[8] ? (10'd0 - {sobelX[8], sobelX}) : {1'b0, sobelX};
      abs_y   = sobelY[8] ? (10'd0 - {sobelY[8], sobelY}) : {1'b0, sobelY};
      mag_sum = abs_x + abs_y;
   end

`ifdef SOBEL_MAG_WINDOW_EN
   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   localparam logic [17:0] START_A = 18'(STARTADDRESS);
   localparam logic [17:0] END_A   = 18'(ENDADDRESS);

   state_t      state;
   state_t      state_nxt;
   logic [17:0] counter;
   logic [17:0] counter_nxt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= IDLE;
         counter <= 18'd0;
      end else begin
         state   <= state_nxt;
         counter <= counter_nxt;
      end
   end

   // The counter value in a RUN cycle is the index of the sample presented in that cycle.
   always_comb begin
      state_nxt   = state;
      counter_nxt = counter;
      gate        = 1'b0;
      case (state)
         IDLE: begin
            counter_nxt = 18'd0;
            if (startEn) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            gate = (counter >= START_A) && (counter <= END_A);
            if (counter == END_A) begin
               state_nxt   = IDLE;
               counter_nxt = 18'd0;
            end else begin
               counter_nxt = counter + 18'd1;
            end
         end
         default: begin
            state_nxt   = IDLE;
            counter_nxt = 18'd0;
         end
      endcase
   end
`else
   logic unused_cfg;

   assign gate       = 1'b1;
   assign unused_cfg = startEn ^ (STARTADDRESS > ENDADDRESS);
`endif

   always_comb begin
      mag_half = unnormalisedMag >> 1;
   end

   // Gate rides alongside its sample so the window edges line up with the pipeline.
   always_ff @(posedge clk) begin
      if (!reset) begin
         unnormalisedMag <= 10'd0;
         gate_q          <= 1'b0;
         normalisedMag   <= 8'd0;
      end else begin
         unnormalisedMag <= mag_sum;
         gate_q          <= gate;
         if (!gate_q) begin
            normalisedMag <= 8'd0;
         end else if (mag_half > 10'd255) begin
            normalisedMag <= 8'hFF;
         end else begin
            normalisedMag <= mag_half[7:0];
         end
      end
   end

endmodule

// File: tb/tb_sobel_mag.sv
// Scoreboard bench for sobel_mag: driver pushes expected results, a negedge monitor pops and compares.
module tb_sobel_mag;

   localparam int S_ADDR = 4;
   localparam int E_ADDR = 9;

   logic       clk = 1'b0;
   logic       reset;
   logic       startEn;
   logic [8:0] sobelX;
   logic [8:0] sobelY;
   logic [7:0] normalisedMag;

   always #5 clk = ~clk;

   sobel_mag #(.STARTADDRESS(S_ADDR), .ENDADDRESS(E_ADDR)) dut (
      .clk           (clk),
      .reset         (reset),
      .startEn       (startEn),
      .sobelX        (sobelX),
      .sobelY        (sobelY),
      .normalisedMag (normalisedMag)
   );

   typedef struct {
      int due;
      int val;
   } exp_t;

   exp_t nq[$];
   exp_t uq[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   // Reference view of the address window: is a run active, and which index comes next.
   bit   run_act = 1'b0;
   int   run_idx = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic drive(input int x, input int y, input bit st, input bit rs);
      int ax, ay, u, n;
      bit g, found;
      @(negedge clk);
      sobelX  = 9'(x);
      sobelY  = 9'(y);
      startEn = st;
      reset   = rs;
      ax = (x < 0) ? -x : x;
      ay = (y < 0) ? -y : y;
      u  = ax + ay;
      n  = (u / 2 > 255) ? 255 : u / 2;
`ifdef SOBEL_MAG_WINDOW_EN
      g = run_act && (run_idx >= S_ADDR) && (run_idx <= E_ADDR);
`else
      g = 1'b1;
`endif
      if (!rs) begin
         // Reset clears the output register on this edge, killing the sample already in flight.
         found = 1'b0;
         foreach (nq[i]) begin
            if (nq[i].due == cyc + 1) begin
               nq[i].val = 0;
               found = 1'b1;
            end
         end
         if (!found) nq.push_back('{cyc + 1, 0});
         nq.push_back('{cyc + 2, 0});
         uq.push_back('{cyc + 1, 0});
         run_act = 1'b0;
         run_idx = 0;
      end else begin
         nq.push_back('{cyc + 2, g ? n : 0});
         uq.push_back('{cyc + 1, u});
         if (run_act) begin
            if (run_idx == E_ADDR) run_act = 1'b0;
            else run_idx++;
         end else if (st) begin
            run_act = 1'b1;
            run_idx = 0;
         end
      end
   endtask

   exp_t me;
   exp_t mu;

   always @(negedge clk) begin
      if (nq.size() > 0 && nq[0].due == cyc) begin
         me = nq.pop_front();
         checks++;
         if (normalisedMag !== 8'(me.val)) begin
            errors++;
            $display("FAIL normalisedMag cyc=%0d got=%0d expected=%0d", cyc, normalisedMag, me.val);
         end
      end
      if (uq.size() > 0 && uq[0].due == cyc) begin
         mu = uq.pop_front();
         checks++;
         if (dut.unnormalisedMag !== 10'(mu.val)) begin
            errors++;
            $display("FAIL unnormalisedMag cyc=%0d got=%0d expected=%0d", cyc, dut.unnormalisedMag, mu.val);
         end
      end
   end

   initial begin
      int x, y;
      bit st, rs;
      reset   = 1'b0;
      startEn = 1'b0;
      sobelX  = 9'd0;
      sobelY  = 9'd0;

      // Reset held two cycles with live inputs; reset beats startEn.
      drive(100, -50, 1'b0, 1'b0);
      drive(-7, 33, 1'b1, 1'b0);
      repeat (5) drive(100, 0, 1'b0, 1'b1);

      for (int v = -255; v <= 255; v++) drive(v, v, 1'b0, 1'b1);

      drive(-256, -256, 1'b0, 1'b1);
      drive(3, -4, 1'b0, 1'b1);
      drive(255, -256, 1'b0, 1'b1);
      drive(-256, 255, 1'b0, 1'b1);
      drive(0, 0, 1'b0, 1'b1);

      // Window run with a second start mid-run.
      drive(100, 0, 1'b1, 1'b1);
      for (int i = 0; i < 20; i++) drive(100, 0, (i == 3), 1'b1);

      // Reset at index 6, then restart.
      drive(100, 0, 1'b1, 1'b1);
      for (int i = 0; i < 6; i++) drive(100, 0, 1'b0, 1'b1);
      drive(100, 0, 1'b0, 1'b0);
      drive(100, 0, 1'b1, 1'b1);
      repeat (16) drive(100, 0, 1'b0, 1'b1);

      repeat (400) begin
         x  = int'($urandom_range(0, 511)) - 256;
         y  = int'($urandom_range(0, 511)) - 256;
         st = ($urandom_range(0, 19) == 0);
         rs = ($urandom_range(0, 49) != 0);
         drive(x, y, st, rs);
      end

      repeat (4) drive(0, 0, 1'b0, 1'b1);
      for (int k = 0; k < 10 && (nq.size() > 0 || uq.size() > 0); k++) @(negedge clk);
      @(posedge clk);
      checks++;
      if (nq.size() != 0 || uq.size() != 0) begin
         errors++;
         $display("FAIL drain pending_norm=%0d pending_unnorm=%0d expected=0", nq.size(), uq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
